la_trigger: RTL and testbench

Trigger and capture controller for the logic-analyser datapath. It sits directly downstream of the input `buffer` stage and consumes its 16-bit `out` sample bus every clock. While armed it streams samples into an external ring-buffer sample RAM. It detects a mask/value trigger, records where the trigger landed, writes a programmable number of post-trigger samples, then stops and flags completion.

---
 rtl/la_trigger.sv | 114 +++++++++++
 tb/tb_la_trigger.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/la_trigger.sv
// la_trigger: mask/value trigger and ring-buffer capture controller for the logic-analyser datapath.
// Optional rising-edge trigger qualification when LA_TRIGGER_EDGE_EN is defined.
module la_trigger #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     sample,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     trig_mask,
    input  logic [WIDTH-1:0]     trig_value,
`ifdef LA_TRIGGER_EDGE_EN
    input  logic [WIDTH-1:0]     trig_edge,
`endif
    input  logic [ADDR_BITS-1:0] post_count,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_data,
    output logic                 busy,
    output logic                 triggered,
    output logic [ADDR_BITS-1:0] trig_addr,
    output logic                 wrapped,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] wptr_q, cnt_q, post_q, mem_addr_q, trig_addr_q;
    logic [WIDTH-1:0]     mem_data_q, miss_d;
    logic                 mem_we_q, busy_q, triggered_q, wrapped_q, done_q, match_d;

`ifdef LA_TRIGGER_EDGE_EN
    logic [WIDTH-1:0] prev_q;
    // Edge bits miss unless the bit just went 0->1; level bits miss on any value difference.
    assign miss_d = trig_mask & ((trig_edge & ~(~prev_q & sample)) | (~trig_edge & (sample ^ trig_value)));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= '0;
        else      prev_q <= sample;
    end
`else
    assign miss_d = trig_mask & (sample ^ trig_value);
`endif
    assign match_d = ~|miss_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            post_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            busy_q      <= 1'b0;
            triggered_q <= 1'b0;
            trig_addr_q <= '0;
            wrapped_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                triggered_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        done_q <= (state_q == DONE);
                        busy_q <= 1'b0;
                        if (arm) begin
                            state_q     <= ARMED;
                            wptr_q      <= '0;
                            wrapped_q   <= 1'b0;
                            triggered_q <= 1'b0;
                            done_q      <= 1'b0;
                            busy_q      <= 1'b1;
                            post_q      <= post_count;
                        end
                    end
                    default: begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= wptr_q;
                        mem_data_q <= sample;
                        wptr_q     <= wptr_q + 1'b1;
                        // Writes are gapless, so address 0 after a write can only be a wrap.
                        if (mem_we_q && wptr_q == '0) wrapped_q <= 1'b1;
                        if (state_q == ARMED && match_d) begin
                            triggered_q <= 1'b1;
                            trig_addr_q <= wptr_q;
                            cnt_q       <= post_q;
                            state_q     <= (post_q == '0) ? DONE : POST;
                        end
                        if (state_q == POST) begin
                            cnt_q <= cnt_q - 1'b1;
                            if (cnt_q == ADDR_BITS'(1)) state_q <= DONE;
                        end
                    end
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign busy      = busy_q;
    assign triggered = triggered_q;
    assign trig_addr = trig_addr_q;
    assign wrapped   = wrapped_q;
    assign done      = done_q;
endmodule

// File: tb/tb_la_trigger.sv
// tb_la_trigger: directed checks of la_trigger capture, trigger, wrap, abort and reset behaviour.
module tb_la_trigger;
    logic        clk = 1'b0, rst = 1'b0;
    logic [15:0] sample = '0, trig_mask = '0, trig_value = '0;
    logic        arm = 1'b0, abort = 1'b0, arm4 = 1'b0, abort4 = 1'b0;
    logic [9:0]  post_count = '0;
    logic [3:0]  post4 = '0;
`ifdef LA_TRIGGER_EDGE_EN
    logic [15:0] trig_edge = '0;
`endif
    logic        mem_we, busy, triggered, wrapped, done;
    logic [9:0]  mem_addr, trig_addr;
    logic [15:0] mem_data;
    logic        we4, busy4, trig4, wrap4, done4;
    logic [3:0]  addr4, taddr4;
    logic [15:0] data4;
    int          total = 0, passes = 0;

    la_trigger #(.WIDTH(16), .ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst), .sample(sample), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value),
`ifdef LA_TRIGGER_EDGE_EN
        .trig_edge(trig_edge),
`endif
        .post_count(post_count), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .triggered(triggered), .trig_addr(trig_addr), .wrapped(wrapped), .done(done)
    );

    la_trigger #(.WIDTH(16), .ADDR_BITS(4)) u4 (
        .clk(clk), .rst(rst), .sample(sample), .arm(arm4), .abort(abort4),
        .trig_mask(trig_mask), .trig_value(trig_value),
`ifdef LA_TRIGGER_EDGE_EN
        .trig_edge(trig_edge),
`endif
        .post_count(post4), .mem_we(we4), .mem_addr(addr4), .mem_data(data4),
        .busy(busy4), .triggered(trig4), .trig_addr(taddr4), .wrapped(wrap4), .done(done4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    initial begin
        #1;
        check("reset_outputs", 32'({mem_we, busy, triggered, wrapped, done, mem_addr, trig_addr}), 0);
        check("reset_data", 32'(mem_data), 0);
        step();
        rst = 1'b1;

        // Ramp capture: trigger on 0x0010, four post-trigger samples, arm toggled throughout
        trig_mask = 16'hFFFF; trig_value = 16'h0010; post_count = 10'd4;
        sample = 16'h0000; arm = 1'b1;
        step();
        arm = 1'b0; sample = 16'h0001;
        check("arm_busy", 32'(busy), 1);
        check("arm_no_we", 32'(mem_we), 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("ramp_we", 32'(mem_we), 1);
            check("ramp_addr", 32'(mem_addr), 32'(i));
            check("ramp_data", 32'(mem_data), 32'(i + 1));
            if (i == 14) check("pre_trig", 32'(triggered), 0);
            if (i == 15) check("trig_addr", 32'({triggered, trig_addr}), 32'({1'b1, 10'd15}));
            if (i == 19) check("last_write_not_done", 32'(done), 0);
            arm = (i < 19) ? i[0] : 1'b0;
            sample = 16'(i + 2);
        end
        step();
        check("ramp_done", 32'({done, mem_we, busy}), 32'b100);
        check("ramp_hold", 32'({triggered, wrapped, trig_addr}), 32'({1'b1, 1'b0, 10'd15}));
        step();
        check("done_stays", 32'({done, mem_we}), 32'b10);

        // Re-arm from DONE with zero mask and zero post count
        trig_mask = 16'h0000; post_count = 10'd0; sample = 16'hABCD; arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm_done_clr", 32'({done, busy, triggered}), 32'b010);
        step();
        check("zero_write", 32'({mem_we, mem_addr, mem_data}), 32'({1'b1, 10'd0, 16'hABCD}));
        check("zero_trig", 32'({triggered, trig_addr}), 32'({1'b1, 10'd0}));
        step();
        check("zero_done", 32'({done, mem_we, busy}), 32'b100);
        step();
        check("zero_one_write", 32'(mem_we), 0);

        // Asynchronous reset while in POST
        post_count = 10'd10; arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        step();
        check("post_busy", 32'({busy, mem_we, mem_addr}), 32'({2'b11, 10'd1}));
        #2 rst = 1'b0;
        #1;
        check("async_rst", 32'({mem_we, busy, triggered, wrapped, done, mem_addr, trig_addr}), 0);
        check("async_rst_data", 32'(mem_data), 0);
        step();
        rst = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'({mem_we, busy, done}), 0);

        // Wrap on the 16-deep instance, trigger never matches, then abort
        trig_mask = 16'hFFFF; trig_value = 16'hFFFF; sample = 16'h1234; arm4 = 1'b1;
        step();
        arm4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("wrap_addr", 32'(addr4), 32'(i % 16));
            check("wrap_flag", 32'({wrap4, busy4, we4}), 32'({i >= 16, 2'b11}));
        end
        abort4 = 1'b1;
        step();
        abort4 = 1'b0;
        check("abort", 32'({busy4, we4, done4, trig4}), 0);
        check("abort_hold_wrap", 32'(wrap4), 1);

`ifdef LA_TRIGGER_EDGE_EN
        // Rising-edge trigger on bit 0: high at arm, low, then high again
        trig_edge = 16'h0001; trig_mask = 16'h0001; trig_value = 16'h0000;
        post_count = 10'd0; sample = 16'h0001; arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        check("edge_no_first", 32'(triggered), 0);
        sample = 16'h0000;
        step();
        check("edge_no_fall", 32'(triggered), 0);
        sample = 16'h0001;
        step();
        check("edge_rise", 32'({triggered, trig_addr}), 32'({1'b1, 10'd2}));
        step();
        check("edge_done", 32'(done), 1);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
